// File: rtl/triple_pkg.sv
// Shared constants and reference function for the x3 scaling unit.
package triple_pkg;

  localparam int TRIPLE_WIDTH = 4;
  localparam int TRIPLE_OUT_W = TRIPLE_WIDTH + 2;

  function automatic int unsigned triple_ref(input int unsigned a);
    return a * 3;
  endfunction

endpackage

// File: rtl/add_rca.sv
// N-bit ripple-carry adder built from a chain of generated full-adder cells.
module add_rca
  import triple_pkg::*;
#(
  parameter int N = TRIPLE_WIDTH + 1
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/triple.sv
// Registered multiply-by-three: result = (a<<1) + a, one cycle latency, with valid flag.
module triple
  import triple_pkg::*;
#(
  parameter  int WIDTH = TRIPLE_WIDTH,
  localparam int OUT_W = WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  output logic [OUT_W-1:0] result
);

  logic [WIDTH:0]   x_p0;
  logic [WIDTH:0]   y_p0;
  logic [WIDTH:0]   sum_p0;
  logic             cout_p0;
  logic [OUT_W-1:0] result_p1;
  logic             vld_p1;

  // Stage 0: the LSB of 2a is always zero, so a WIDTH+1 bit adder suffices and its carry is the MSB
  assign x_p0 = {a, 1'b0};
  assign y_p0 = {1'b0, a};

  add_rca #(
    .N(WIDTH + 1)
  ) u_add (
    .x   (x_p0),
    .y   (y_p0),
    .cin (1'b0),
    .sum (sum_p0),
    .cout(cout_p0)
  );

  // Stage 1: result only loads on valid input, so a don't-care operand never reaches it
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        result_p1 <= {cout_p0, sum_p0};
      end
    end
  end

  assign out_valid = vld_p1;
  assign result    = result_p1;

endmodule

// File: tb/tb_triple.sv
// Directed and random checks of the x3 unit at WIDTH=4 and WIDTH=8.
module tb_triple;
  import triple_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid4;
  logic [3:0] a4;
  logic       out_valid4;
  logic [5:0] result4;
  logic       in_valid8;
  logic [7:0] a8;
  logic       out_valid8;
  logic [9:0] result8;

  int total;
  int bad;

  triple #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid4),
    .a        (a4),
    .out_valid(out_valid4),
    .result   (result4)
  );

  triple #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid8),
    .a        (a8),
    .out_valid(out_valid8),
    .result   (result8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          dir_a[5]   = '{0, 1, 3, 5, 10};
  int          dir_exp[5] = '{0, 3, 9, 15, 30};
  logic [5:0]  exp_r4;
  logic        exp_v4;
  logic [9:0]  exp_r8;
  logic        exp_v8;

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid4 = 1'b1;
    a4        = 4'd7;
    in_valid8 = 1'b0;
    a8        = 8'd0;

    // reset held with a valid operand present
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_result", 32'(result4), 32'd0);
      chk("rst_valid", 32'(out_valid4), 32'd0);
    end
    rst = 1'b0;

    // consecutive operands
    for (int i = 0; i < 5; i++) begin
      in_valid4 = 1'b1;
      a4        = 4'(dir_a[i]);
      tick();
      chk("seq_result", 32'(result4), 32'(dir_exp[i]));
      chk("seq_valid", 32'(out_valid4), 32'd1);
    end

    // maximum operand
    a4 = 4'd15;
    tick();
    chk("max_result", 32'(result4), 32'd45);
    chk("max_valid", 32'(out_valid4), 32'd1);

    // hold while idle, X on the operand
    a4 = 4'd10;
    tick();
    tick();
    chk("hold_pre", 32'(result4), 32'd30);
    in_valid4 = 1'b0;
    a4        = 4'bxxxx;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_result", 32'(result4), 32'd30);
      chk("hold_valid", 32'(out_valid4), 32'd0);
    end

    // reset mid-stream flushes the pending operand
    in_valid4 = 1'b1;
    a4        = 4'd2;
    tick();
    chk("flush_pre", 32'(result4), 32'd6);
    rst = 1'b1;
    a4  = 4'd6;
    tick();
    chk("flush_result", 32'(result4), 32'd0);
    chk("flush_valid", 32'(out_valid4), 32'd0);
    rst = 1'b0;
    a4  = 4'd9;
    tick();
    chk("post_rst_result", 32'(result4), 32'd27);
    chk("post_rst_valid", 32'(out_valid4), 32'd1);

    // random vectors on both widths
    exp_r4 = 6'd27;
    exp_v4 = 1'b1;
    exp_r8 = 10'd0;
    exp_v8 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      in_valid4 = 1'($urandom_range(0, 3) != 0);
      a4        = 4'($urandom);
      in_valid8 = 1'($urandom_range(0, 3) != 0);
      a8        = 8'($urandom);
      exp_v4    = in_valid4;
      exp_v8    = in_valid8;
      if (in_valid4) exp_r4 = 6'(triple_ref(32'(a4)));
      if (in_valid8) exp_r8 = 10'(triple_ref(32'(a8)));
      tick();
      chk("rnd4_result", 32'(result4), 32'(exp_r4));
      chk("rnd4_valid", 32'(out_valid4), 32'(exp_v4));
      chk("rnd8_result", 32'(result8), 32'(exp_r8));
      chk("rnd8_valid", 32'(out_valid8), 32'(exp_v8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
